// File: rtl/accel_spi_responder.sv
// accel_spi_responder: SPI mode-0 slave emulating an accelerometer register interface.
// Define ACCEL_SPI_RESPONDER_WR_EN to build the register write path (power_ctl, soft reset).
module accel_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PART_ID     = 8'hF2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x_val,
    input  logic [7:0] y_val,
    input  logic [7:0] z_val,
    input  logic       SCLK,
    input  logic       CSN,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    output logic [7:0] power_ctl,
    output logic       xfer_done,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD        = 3'd1,
        READ_ADDR  = 3'd2,
        READ_DATA  = 3'd3,
        WRITE_ADDR = 3'd4,
        WRITE_DATA = 3'd5,
        IGNORE     = 3'd6
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] flush_q, flush_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   csn_prev_q, csn_prev_d;
    logic                   armed_q, armed_d;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic [7:0] miso_sr_q, miso_sr_d;
    logic       load_pending_q, load_pending_d;
    logic       byte_seen_q, byte_seen_d;
    logic [7:0] snap_x_q, snap_x_d;
    logic [7:0] snap_y_q, snap_y_d;
    logic [7:0] snap_z_q, snap_z_d;
    logic       xfer_done_q, xfer_done_d;
    logic       cmd_err_q, cmd_err_d;

    logic       sclk_s, csn_s, mosi_s;
    logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [7:0] rx_byte;
    logic [7:0] fetch_addr;
    logic [7:0] rd_lookup;

`ifdef ACCEL_SPI_RESPONDER_WR_EN
    logic [7:0] power_ctl_q, power_ctl_d;
    assign power_ctl = power_ctl_q;
`else
    assign power_ctl = 8'h00;
`endif

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;
    assign rx_byte   = {rx_shift_q, mosi_s};

    assign miso_oe   = (state_q == READ_DATA);
    assign MISO      = miso_oe & miso_sr_q[7];
    assign xfer_done = xfer_done_q;
    assign cmd_err   = cmd_err_q;

    // armed stays low until CSN has been seen high through a flushed synchronizer,
    // so a CSN held low across reset release cannot open a transaction.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], CSN};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        csn_prev_d  = csn_s;
        armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & csn_s);
    end

    // Register lookup for the byte about to be returned: the freshly received
    // address in READ_ADDR, otherwise the next auto-incremented address.
    always_comb begin
        fetch_addr = (state_q == READ_ADDR) ? rx_byte : addr_q + 8'd1;
        case (fetch_addr)
            8'h00:   rd_lookup = DEVID_AD;
            8'h01:   rd_lookup = DEVID_MST;
            8'h02:   rd_lookup = PART_ID;
            8'h08:   rd_lookup = snap_x_q;
            8'h09:   rd_lookup = snap_y_q;
            8'h0A:   rd_lookup = snap_z_q;
            8'h2D:   rd_lookup = power_ctl;
            default: rd_lookup = 8'h00;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        addr_d         = addr_q;
        rd_byte_d      = rd_byte_q;
        miso_sr_d      = miso_sr_q;
        load_pending_d = load_pending_q;
        byte_seen_d    = byte_seen_q;
        snap_x_d       = snap_x_q;
        snap_y_d       = snap_y_q;
        snap_z_d       = snap_z_q;
        xfer_done_d    = 1'b0;
        cmd_err_d      = 1'b0;
`ifdef ACCEL_SPI_RESPONDER_WR_EN
        power_ctl_d    = power_ctl_q;
`endif

        if (csn_rise) begin
            // CSN release wins over any SCLK edge seen in the same cycle.
            state_d        = IDLE;
            xfer_done_d    = byte_seen_q;
            byte_seen_d    = 1'b0;
            load_pending_d = 1'b0;
            miso_sr_d      = 8'h00;
        end else if (csn_fall && armed_q) begin
            state_d     = CMD;
            bit_cnt_d   = 3'd0;
            byte_seen_d = 1'b0;
            snap_x_d    = x_val;
            snap_y_d    = y_val;
            snap_z_d    = z_val;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                rx_shift_d = rx_byte[6:0];
                if (bit_cnt_q == 3'd7) begin
                    byte_seen_d = 1'b1;
                    case (state_q)
                        CMD: begin
                            case (rx_byte)
                                8'h0B: state_d = READ_ADDR;
`ifdef ACCEL_SPI_RESPONDER_WR_EN
                                8'h0A: state_d = WRITE_ADDR;
`else
                                8'h0A: state_d = IGNORE;
`endif
                                default: begin
                                    state_d   = IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                        READ_ADDR: begin
                            addr_d         = rx_byte;
                            rd_byte_d      = rd_lookup;
                            load_pending_d = 1'b1;
                            state_d        = READ_DATA;
                        end
                        READ_DATA: begin
                            addr_d         = addr_q + 8'd1;
                            rd_byte_d      = rd_lookup;
                            load_pending_d = 1'b1;
                        end
`ifdef ACCEL_SPI_RESPONDER_WR_EN
                        WRITE_ADDR: begin
                            addr_d  = rx_byte;
                            state_d = WRITE_DATA;
                        end
                        WRITE_DATA: begin
                            if (addr_q == 8'h2D) begin
                                power_ctl_d = rx_byte;
                            end else if (addr_q == 8'h1F && rx_byte == 8'h52) begin
                                power_ctl_d = 8'h00;
                            end
                            addr_d = addr_q + 8'd1;
                        end
`endif
                        default: state_d = state_q;
                    endcase
                end
            end else if (sclk_fall && state_q == READ_DATA) begin
                if (load_pending_q) begin
                    miso_sr_d      = rd_byte_q;
                    load_pending_d = 1'b0;
                end else begin
                    miso_sr_d = {miso_sr_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q    <= '0;
            csn_sync_q     <= '1;
            mosi_sync_q    <= '0;
            flush_q        <= '0;
            sclk_prev_q    <= 1'b0;
            csn_prev_q     <= 1'b1;
            armed_q        <= 1'b0;
            state_q        <= IDLE;
            bit_cnt_q      <= 3'd0;
            rx_shift_q     <= 7'd0;
            addr_q         <= 8'h00;
            rd_byte_q      <= 8'h00;
            miso_sr_q      <= 8'h00;
            load_pending_q <= 1'b0;
            byte_seen_q    <= 1'b0;
            snap_x_q       <= 8'h00;
            snap_y_q       <= 8'h00;
            snap_z_q       <= 8'h00;
            xfer_done_q    <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            csn_sync_q     <= csn_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            flush_q        <= flush_d;
            sclk_prev_q    <= sclk_prev_d;
            csn_prev_q     <= csn_prev_d;
            armed_q        <= armed_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            addr_q         <= addr_d;
            rd_byte_q      <= rd_byte_d;
            miso_sr_q      <= miso_sr_d;
            load_pending_q <= load_pending_d;
            byte_seen_q    <= byte_seen_d;
            snap_x_q       <= snap_x_d;
            snap_y_q       <= snap_y_d;
            snap_z_q       <= snap_z_d;
            xfer_done_q    <= xfer_done_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

`ifdef ACCEL_SPI_RESPONDER_WR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            power_ctl_q <= 8'h00;
        end else begin
            power_ctl_q <= power_ctl_d;
        end
    end
`endif

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: SPI mode-0 master driver, read vector table,
// expected-byte queue and hand-written write/abort/reset sequences.
module tb_accel_spi_responder;

    logic       clk;
    logic       rst;
    logic [7:0] x_val, y_val, z_val;
    logic       SCLK, CSN, MOSI;
    logic       MISO, miso_oe, xfer_done, cmd_err;
    logic [7:0] power_ctl;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int cmd_err_cnt = 0;
    logic [7:0] exp_q[$];

`ifdef ACCEL_SPI_RESPONDER_WR_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[9];

    accel_spi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .x_val     (x_val),
        .y_val     (y_val),
        .z_val     (z_val),
        .SCLK      (SCLK),
        .CSN       (CSN),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .miso_oe   (miso_oe),
        .power_ctl (power_ctl),
        .xfer_done (xfer_done),
        .cmd_err   (cmd_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done) xfer_cnt++;
        if (cmd_err) cmd_err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name, input logic [7:0] act);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %0h but no expected byte queued", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    // driver: SCLK half period of 4 clk, MISO sampled just before each rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output int oe_cnt);
        rx = 8'h00;
        oe_cnt = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            SCLK = 1'b0;
            MOSI = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = MISO;
            if (miso_oe) oe_cnt++;
            SCLK = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        CSN = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        CSN = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input int nbytes);
        logic [7:0] rx;
        int oe;
        int xd0;
        xd0 = xfer_cnt;
        cs_low();
        spi_xfer(8'h0B, 8, rx, oe);
        check({name, "_cmd_oe"}, oe, 0);
        spi_xfer(addr, 8, rx, oe);
        check({name, "_addr_oe"}, oe, 0);
        for (int b = 0; b < nbytes; b++) begin
            spi_xfer(8'h00, 8, rx, oe);
            check({name, "_data_oe"}, oe, 8);
            sb_compare({name, "_data"}, rx);
        end
        cs_high();
        check({name, "_oe_idle"}, miso_oe, 0);
        check({name, "_xfer_done"}, xfer_cnt - xd0, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] d0,
                            input logic [7:0] d1, input int nbytes);
        logic [7:0] rx;
        int oe;
        cs_low();
        spi_xfer(8'h0A, 8, rx, oe);
        spi_xfer(addr, 8, rx, oe);
        spi_xfer(d0, 8, rx, oe);
        if (nbytes > 1) spi_xfer(d1, 8, rx, oe);
        cs_high();
    endtask

    initial begin
        logic [7:0] rx;
        int oe;
        int xd0;
        int ce0;

        vecs[0] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'hAD};
        vecs[1] = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h1D};
        vecs[2] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'hF2};
        vecs[3] = '{8'h08, 8'h5C, 8'h22, 8'h33, 8'h5C};
        vecs[4] = '{8'h09, 8'h11, 8'hA7, 8'h33, 8'hA7};
        vecs[5] = '{8'h0A, 8'h11, 8'h22, 8'h81, 8'h81};
        vecs[6] = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        vecs[7] = '{8'h2D, 8'h11, 8'h22, 8'h33, 8'h00};
        vecs[8] = '{8'h7F, 8'h11, 8'h22, 8'h33, 8'h00};

        rst = 1'b1;
        SCLK = 1'b0;
        CSN = 1'b1;
        MOSI = 1'b0;
        x_val = 8'h00;
        y_val = 8'h00;
        z_val = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_power_ctl", power_ctl, 8'h00);
        check("rst_xfer_done", xfer_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            x_val = vecs[i].x;
            y_val = vecs[i].y;
            z_val = vecs[i].z;
            exp_q.push_back(vecs[i].exp);
            do_read("tbl_read", vecs[i].addr, 1);
        end

        // snapshot: x changes after the command byte, reads keep the latched values
        x_val = 8'h12;
        y_val = 8'h34;
        cs_low();
        spi_xfer(8'h0B, 8, rx, oe);
        x_val = 8'h99;
        y_val = 8'h77;
        spi_xfer(8'h08, 8, rx, oe);
        spi_xfer(8'h00, 8, rx, oe);
        exp_q.push_back(8'h12);
        sb_compare("snap_x", rx);
        spi_xfer(8'h00, 8, rx, oe);
        exp_q.push_back(8'h34);
        sb_compare("snap_y", rx);
        cs_high();

        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAD);
        do_read("wrap", 8'hFF, 2);

        // writes
        ce0 = cmd_err_cnt;
        do_write(8'h2D, 8'h02, 8'h00, 1);
        check("wr_power_02", power_ctl, WR ? 8'h02 : 8'h00);
        check("wr_no_cmd_err", cmd_err_cnt - ce0, 0);
        exp_q.push_back(WR ? 8'h02 : 8'h00);
        do_read("rd_power", 8'h2D, 1);
        do_write(8'h2C, 8'h11, 8'h05, 2);
        check("wr_burst_inc", power_ctl, WR ? 8'h05 : 8'h00);
        cs_low();
        spi_xfer(8'h0A, 8, rx, oe);
        spi_xfer(8'h2D, 8, rx, oe);
        spi_xfer(8'h08, 4, rx, oe);
        cs_high();
        check("wr_partial_discard", power_ctl, WR ? 8'h05 : 8'h00);
        do_write(8'h1F, 8'h51, 8'h00, 1);
        check("wr_soft_rst_wrong_key", power_ctl, WR ? 8'h05 : 8'h00);
        do_write(8'h1F, 8'h52, 8'h00, 1);
        check("wr_soft_rst", power_ctl, 8'h00);

        // bad command
        xd0 = xfer_cnt;
        ce0 = cmd_err_cnt;
        cs_low();
        spi_xfer(8'h5A, 8, rx, oe);
        spi_xfer(8'hFF, 8, rx, oe);
        check("badcmd_miso", rx, 8'h00);
        check("badcmd_oe", oe, 0);
        cs_high();
        check("badcmd_cmd_err", cmd_err_cnt - ce0, 1);
        check("badcmd_xfer_done", xfer_cnt - xd0, 1);

        // abort inside the address byte
        xd0 = xfer_cnt;
        cs_low();
        spi_xfer(8'h0B, 8, rx, oe);
        spi_xfer(8'h2D, 4, rx, oe);
        cs_high();
        check("abort_xfer_done", xfer_cnt - xd0, 1);
        check("abort_oe", miso_oe, 0);
        check("abort_power_ctl", power_ctl, 8'h00);

        // reset during the data byte, then CSN kept low across reset release
        cs_low();
        spi_xfer(8'h0B, 8, rx, oe);
        spi_xfer(8'h02, 8, rx, oe);
        spi_xfer(8'h00, 3, rx, oe);
        check("rstmid_first_bits", rx[7:5], 3'b111);
        @(negedge clk);
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_pre_miso", MISO, 1);
        check("rstmid_pre_oe", miso_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_miso", MISO, 0);
        check("rstmid_oe", miso_oe, 0);
        check("rstmid_xfer_done", xfer_done, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        xd0 = xfer_cnt;
        ce0 = cmd_err_cnt;
        spi_xfer(8'h0B, 8, rx, oe);
        spi_xfer(8'h02, 8, rx, oe);
        spi_xfer(8'h00, 8, rx, oe);
        check("held_low_oe", oe, 0);
        check("held_low_miso", rx, 8'h00);
        cs_high();
        check("held_low_xfer_done", xfer_cnt - xd0, 0);
        check("held_low_cmd_err", cmd_err_cnt - ce0, 0);

        exp_q.push_back(8'hF2);
        do_read("post_rst_read", 8'h02, 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
